id_stage_pipelined: RTL and testbench

Parametrised successor to the decode stage. Decodes one instruction per cycle, reads an internal register file and evaluates the condition code. Detects RAW hazards against the EXE and MEM stages and drives a stall to fetch. Owns the ID/EXE pipeline register, with stall-hold, bubble insertion and flush. Sits between the IF/ID register and the EXE stage.

---
 rtl/id_pkg.sv | 118 +++++++++++
 rtl/id_stage_pipelined_if.sv | 41 ++++
 rtl/reg_file_bypass.sv | 47 ++++
 rtl/id_stage_pipelined.sv | 135 +++++++++++++
 tb/tb_id_stage_pipelined.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: ALU commands, instruction fields,
// condition codes, the registered control bundle and the pure decode helpers.
package id_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h4,
    OP_ADC = 4'h5, OP_SBC = 4'h6, OP_TST = 4'h8, OP_CMP = 4'hA,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_MVN = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_DP = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10, MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic [3:0] exec_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       imm;
    logic       branch;
    logic       s;
  } ctrl_t;

  // Anything not recognised collapses to an all-zero bundle.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[27:26])
      MODE_DP: begin
        c.s     = instr[20];
        c.imm   = instr[25];
        c.wb_en = 1'b1;
        case (instr[24:21])
          OP_MOV: c.exec_cmd = CMD_MOV;
          OP_MVN: c.exec_cmd = CMD_MVN;
          OP_ADD: c.exec_cmd = CMD_ADD;
          OP_ADC: c.exec_cmd = CMD_ADC;
          OP_SUB: c.exec_cmd = CMD_SUB;
          OP_SBC: c.exec_cmd = CMD_SBC;
          OP_AND: c.exec_cmd = CMD_AND;
          OP_ORR: c.exec_cmd = CMD_ORR;
          OP_EOR: c.exec_cmd = CMD_EOR;
          OP_CMP: begin c.exec_cmd = CMD_SUB; c.wb_en = 1'b0; end
          OP_TST: begin c.exec_cmd = CMD_AND; c.wb_en = 1'b0; end
          default: c = '0;
        endcase
      end
      MODE_MEM: begin
        c.exec_cmd = CMD_ADD;
        c.imm      = instr[25];
        if (instr[20]) begin
          c.mem_read = 1'b1;
          c.wb_en    = 1'b1;
        end else begin
          c.mem_write = 1'b1;
        end
      end
      MODE_BR: begin
        c.branch = 1'b1;
        c.imm    = instr[25];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_src1(input logic [31:0] instr);
    logic is_mov;
    is_mov = (instr[27:26] == MODE_DP) &&
             ((instr[24:21] == OP_MOV) || (instr[24:21] == OP_MVN));
    return !(is_mov || (instr[27:26] == MODE_BR));
  endfunction

  // nzcv = {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// ID/EXE boundary: registered instruction fields towards EXE plus the
// flush/ready handshake coming back.
interface id_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 4
);
  logic              valid_out;
  logic [ADDR_W-1:0] pc_out;
  logic [3:0]        exec_cmd;
  logic              mem_read;
  logic              mem_write;
  logic              wb_en_out;
  logic              imm_out;
  logic              branch_out;
  logic              s_out;
  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;
  logic [REG_AW-1:0] dest_out;
  logic [REG_AW-1:0] src1_out;
  logic [REG_AW-1:0] src2_out;
  logic [23:0]       signed_imm;
  logic [11:0]       shift_operand;
  logic              two_src_out;
  logic              flush;
  logic              ex_ready;

  modport master (
    output valid_out, pc_out, exec_cmd, mem_read, mem_write, wb_en_out,
           imm_out, branch_out, s_out, rn_val, rm_val, dest_out, src1_out,
           src2_out, signed_imm, shift_operand, two_src_out,
    input  flush, ex_ready
  );

  modport slave (
    input  valid_out, pc_out, exec_cmd, mem_read, mem_write, wb_en_out,
           imm_out, branch_out, s_out, rn_val, rm_val, dest_out, src1_out,
           src2_out, signed_imm, shift_operand, two_src_out,
    output flush, ex_ready
  );
endinterface

// File: rtl/reg_file_bypass.sv
// Register file with asynchronous reads, posedge write and optional
// same-cycle write-back bypass; out-of-range addresses read 0 and never write.
module reg_file_bypass #(
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 32,
  parameter int WB_BYPASS = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && in_range(waddr)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (in_range(raddr_a)) begin
      if ((WB_BYPASS != 0) && we && (waddr == raddr_a)) rdata_a = wdata;
      else rdata_a = regs[raddr_a];
    end
    if (in_range(raddr_b)) begin
      if ((WB_BYPASS != 0) && we && (waddr == raddr_b)) rdata_b = wdata;
      else rdata_b = regs[raddr_b];
    end
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// Instruction decode stage: decode, operand read, condition check, RAW hazard
// stall generation and the ID/EXE pipeline register with hold/bubble/flush.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int NUM_REGS      = 16,
  parameter int FORWARDING_EN = 0,
  parameter int WB_BYPASS     = 1,
  localparam int REG_AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic [3:0]        status_reg,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exe_wb_en,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_mem_read,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              stall_out,
  id_stage_pipelined_if.master ex_if
);

  // ---- stage p0: combinational decode, operand read, hazard ----
  ctrl_t             ctrl_p0;
  logic [REG_AW-1:0] src1_p0, src2_p0, dest_p0;
  logic              src1_use_p0, two_src_p0;
  logic [DATA_W-1:0] rn_p0, rm_p0;
  logic              hit_exe_p0, hit_mem_p0, hazard_p0, issue_p0, hold_p0;

  ctrl_t             ctrl_p1;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [DATA_W-1:0] rn_p1, rm_p1;
  logic [REG_AW-1:0] dest_p1, src1_p1, src2_p1;
  logic [23:0]       simm_p1;
  logic [11:0]       shop_p1;
  logic              two_src_p1;

  always_comb begin
    ctrl_p0     = decode(instr_in);
    src1_p0     = REG_AW'(instr_in[19:16]);
    dest_p0     = REG_AW'(instr_in[15:12]);
    src2_p0     = ctrl_p0.mem_write ? REG_AW'(instr_in[15:12]) : REG_AW'(instr_in[3:0]);
    src1_use_p0 = uses_src1(instr_in);
    two_src_p0  = ~instr_in[25] | ctrl_p0.mem_write;
  end

  reg_file_bypass #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .WB_BYPASS(WB_BYPASS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr_a(src1_p0),
    .raddr_b(src2_p0),
    .rdata_a(rn_p0),
    .rdata_b(rm_p0)
  );

  // With forwarding, only a load in EXE cannot be forwarded in time.
  always_comb begin
    hit_exe_p0 = exe_wb_en && ((src1_use_p0 && (src1_p0 == exe_dest)) ||
                               (two_src_p0  && (src2_p0 == exe_dest)));
    hit_mem_p0 = mem_wb_en && ((src1_use_p0 && (src1_p0 == mem_dest)) ||
                               (two_src_p0  && (src2_p0 == mem_dest)));
    if (FORWARDING_EN != 0) hazard_p0 = instr_valid && exe_mem_read && hit_exe_p0;
    else                    hazard_p0 = instr_valid && (hit_exe_p0 || hit_mem_p0);
    hold_p0   = vld_p1 && !ex_if.ex_ready;
    issue_p0  = instr_valid && !hazard_p0 && cond_pass(instr_in[31:28], status_reg);
    stall_out = hazard_p0 || hold_p0;
  end

  // ---- stage p1: ID/EXE register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      pc_p1      <= '0;
      rn_p1      <= '0;
      rm_p1      <= '0;
      dest_p1    <= '0;
      src1_p1    <= '0;
      src2_p1    <= '0;
      simm_p1    <= '0;
      shop_p1    <= '0;
      two_src_p1 <= 1'b0;
    end else if (ex_if.flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (!hold_p0) begin
      vld_p1     <= issue_p0;
      ctrl_p1    <= issue_p0 ? ctrl_p0 : '0;
      pc_p1      <= pc_in;
      rn_p1      <= rn_p0;
      rm_p1      <= rm_p0;
      dest_p1    <= dest_p0;
      src1_p1    <= src1_p0;
      src2_p1    <= src2_p0;
      simm_p1    <= instr_in[23:0];
      shop_p1    <= instr_in[11:0];
      two_src_p1 <= two_src_p0;
    end
  end

  assign ex_if.valid_out     = vld_p1;
  assign ex_if.pc_out        = pc_p1;
  assign ex_if.exec_cmd      = ctrl_p1.exec_cmd;
  assign ex_if.mem_read      = ctrl_p1.mem_read;
  assign ex_if.mem_write     = ctrl_p1.mem_write;
  assign ex_if.wb_en_out     = ctrl_p1.wb_en;
  assign ex_if.imm_out       = ctrl_p1.imm;
  assign ex_if.branch_out    = ctrl_p1.branch;
  assign ex_if.s_out         = ctrl_p1.s;
  assign ex_if.rn_val        = rn_p1;
  assign ex_if.rm_val        = rm_p1;
  assign ex_if.dest_out      = dest_p1;
  assign ex_if.src1_out      = src1_p1;
  assign ex_if.src2_out      = src2_p1;
  assign ex_if.signed_imm    = simm_p1;
  assign ex_if.shift_operand = shop_p1;
  assign ex_if.two_src_out   = two_src_p1;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: one instance without and one with EXE
// forwarding, both checked every cycle against a table-driven model.
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic [3:0]  status_reg = '0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        exe_wb_en = 1'b0;
  logic [3:0]  exe_dest = '0;
  logic        exe_mem_read = 1'b0;
  logic        mem_wb_en = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic        stall0, stall1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipelined_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(4)) if0 ();
  id_stage_pipelined_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(4)) if1 ();
  assign if0.flush = flush;
  assign if0.ex_ready = ex_ready;
  assign if1.flush = flush;
  assign if1.ex_ready = ex_ready;

  id_stage_pipelined #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .FORWARDING_EN(0), .WB_BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .instr_valid(instr_valid),
    .status_reg(status_reg), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .stall_out(stall0), .ex_if(if0));

  id_stage_pipelined #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .FORWARDING_EN(1), .WB_BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .instr_valid(instr_valid),
    .status_reg(status_reg), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .stall_out(stall1), .ex_if(if1));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mr, mw, wb, imm, br, s;
    logic [31:0] rn, rm;
    logic [3:0]  dest, src1, src2;
    logic [23:0] simm;
    logic [11:0] shop;
    logic        two;
  } exp_t;

  // Data-processing opcode tables, indexed by instr[24:21].
  localparam logic [3:0] DP_CMD [16] = '{4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
                                          4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};
  localparam logic [15:0] DP_KNOWN = 16'hB577;
  localparam logic [15:0] DP_NOWB  = 16'h0500;

  exp_t        ex [2];
  logic [31:0] mrf [16];

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t m_decode(input logic [31:0] ins);
    exp_t e;
    logic [3:0] op;
    e = zero_exp();
    op = ins[24:21];
    if (ins[27:26] == 2'd0) begin
      if (DP_KNOWN[op]) begin
        e.cmd = DP_CMD[op];
        e.wb  = !DP_NOWB[op];
        e.s   = ins[20];
        e.imm = ins[25];
      end
    end else if (ins[27:26] == 2'd1) begin
      e.cmd = 4'h2;
      e.imm = ins[25];
      e.mr  = ins[20];
      e.wb  = ins[20];
      e.mw  = !ins[20];
    end else if (ins[27:26] == 2'd2) begin
      e.br  = 1'b1;
      e.imm = ins[25];
    end
    e.dest = ins[15:12];
    e.src1 = ins[19:16];
    e.src2 = (ins[27:26] == 2'd1 && !ins[20]) ? ins[15:12] : ins[3:0];
    e.simm = ins[23:0];
    e.shop = ins[11:0];
    e.two  = !ins[25] || (ins[27:26] == 2'd1 && !ins[20]);
    return e;
  endfunction

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cy, v;
    {n, z, cy, v} = st;
    case (c)
      4'd0:  return z;           4'd1:  return !z;
      4'd2:  return cy;          4'd3:  return !cy;
      4'd4:  return n;           4'd5:  return !n;
      4'd6:  return v;           4'd7:  return !v;
      4'd8:  return cy && !z;    4'd9:  return !cy || z;
      4'd10: return n == v;      4'd11: return n != v;
      4'd12: return !z && n == v; 4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_hazard(input int k);
    exp_t d;
    logic s1used, he, hm;
    if (!instr_valid) return 1'b0;
    d = m_decode(instr_in);
    s1used = !((instr_in[27:26] == 2'd0 && (instr_in[24:21] == 4'd13 || instr_in[24:21] == 4'd15))
               || instr_in[27:26] == 2'd2);
    he = exe_wb_en && ((s1used && d.src1 == exe_dest) || (d.two && d.src2 == exe_dest));
    hm = mem_wb_en && ((s1used && d.src1 == mem_dest) || (d.two && d.src2 == mem_dest));
    if (k == 1) return he && exe_mem_read;
    return he || hm;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (wb_en && wb_addr == a) return wb_data;
    return mrf[a];
  endfunction

  task automatic model_step();
    exp_t d;
    logic [31:0] rnv, rmv;
    d = m_decode(instr_in);
    rnv = m_read(d.src1);
    rmv = m_read(d.src2);
    for (int k = 0; k < 2; k++) begin
      if (rst) ex[k] = zero_exp();
      else if (flush) begin
        ex[k].vld = 0; ex[k].cmd = 0; ex[k].mr = 0; ex[k].mw = 0;
        ex[k].wb = 0; ex[k].imm = 0; ex[k].br = 0; ex[k].s = 0;
      end else if (ex[k].vld && !ex_ready) begin
        ex[k] = ex[k];
      end else if (instr_valid && !m_hazard(k) && m_cond(instr_in[31:28], status_reg)) begin
        ex[k] = d;
        ex[k].vld = 1'b1;
        ex[k].pc  = pc_in;
        ex[k].rn  = rnv;
        ex[k].rm  = rmv;
      end else ex[k] = zero_exp();
    end
    if (rst) for (int i = 0; i < 16; i++) mrf[i] = '0;
    else if (wb_en) mrf[wb_addr] = wb_data;
  endtask

  task automatic cmp_inst(input int k, input logic st, input logic vld, input logic [3:0] cmd,
                          input logic mr, input logic mw, input logic wb, input logic imm,
                          input logic br, input logic s, input logic [31:0] pc,
                          input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] d,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [23:0] simm,
                          input logic [11:0] sh, input logic two);
    logic st_e;
    logic [10:0] ca, ce;
    logic [95:0] da, de;
    logic [48:0] fa, fe;
    st_e = m_hazard(k) || (ex[k].vld && !ex_ready);
    checks++;
    if (st !== st_e) begin
      errors++;
      $display("FAIL stall[%0d] t=%0t got %b want %b", k, $time, st, st_e);
    end
    ca = {vld, cmd, mr, mw, wb, imm, br, s};
    ce = {ex[k].vld, ex[k].cmd, ex[k].mr, ex[k].mw, ex[k].wb, ex[k].imm, ex[k].br, ex[k].s};
    checks++;
    if (ca !== ce) begin
      errors++;
      $display("FAIL ctrl[%0d] t=%0t got %b want %b", k, $time, ca, ce);
    end
    if (ex[k].vld) begin
      da = {pc, rn, rm};
      de = {ex[k].pc, ex[k].rn, ex[k].rm};
      fa = {d, s1, s2, simm, sh, two};
      fe = {ex[k].dest, ex[k].src1, ex[k].src2, ex[k].simm, ex[k].shop, ex[k].two};
      checks++;
      if (da !== de) begin
        errors++;
        $display("FAIL data[%0d] t=%0t got %h want %h", k, $time, da, de);
      end
      checks++;
      if (fa !== fe) begin
        errors++;
        $display("FAIL fields[%0d] t=%0t got %h want %h", k, $time, fa, fe);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) ex[k] = zero_exp();
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    cmp_inst(0, stall0, if0.valid_out, if0.exec_cmd, if0.mem_read, if0.mem_write, if0.wb_en_out,
             if0.imm_out, if0.branch_out, if0.s_out, if0.pc_out, if0.rn_val, if0.rm_val,
             if0.dest_out, if0.src1_out, if0.src2_out, if0.signed_imm, if0.shift_operand,
             if0.two_src_out);
    cmp_inst(1, stall1, if1.valid_out, if1.exec_cmd, if1.mem_read, if1.mem_write, if1.wb_en_out,
             if1.imm_out, if1.branch_out, if1.s_out, if1.pc_out, if1.rn_val, if1.rm_val,
             if1.dest_out, if1.src1_out, if1.src2_out, if1.signed_imm, if1.shift_operand,
             if1.two_src_out);
  end

  // ---------------- directed stimulus ----------------
  localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD R1,R2,R3
  localparam logic [31:0] I_ADDEQ = 32'h00821003;
  localparam logic [31:0] I_ADDNV = 32'hF0821003;
  localparam logic [31:0] I_MOV   = 32'hE1A00004; // MOV R0,R4
  localparam logic [31:0] I_CMP   = 32'hE1520003;

  logic [31:0] sweep [10] = '{32'hE5925000, 32'hE5825000, 32'hE1520003, 32'hEA000010,
                               32'hE0621003, 32'hE3E000FF, 32'hE1921003, 32'hE0221003,
                               32'hE0521003, 32'hEC000000};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    instr_in = ins;
    pc_in = pc;
    instr_valid = 1'b1;
  endtask

  initial begin
    cyc(); cyc();
    lit("reset_valid", 32'(if0.valid_out), 32'h0);
    lit("reset_stall", 32'(stall0), 32'h0);
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'd5; cyc();
    wb_addr = 4'd3; wb_data = 32'd7; cyc();
    wb_en = 1'b0;

    // Plain issue
    issue(I_ADD, 32'h100); cyc();
    lit("add_valid", 32'(if0.valid_out), 32'h1);
    lit("add_cmd", 32'(if0.exec_cmd), 32'h2);
    lit("add_rn", if0.rn_val, 32'd5);
    lit("add_rm", if0.rm_val, 32'd7);
    lit("add_dest", 32'(if0.dest_out), 32'h1);
    lit("add_wb", 32'(if0.wb_en_out), 32'h1);

    // EXE RAW: stalls without forwarding, only a load stalls with it
    exe_dest = 4'd2; exe_wb_en = 1'b1; #1;
    lit("exe_haz_stall0", 32'(stall0), 32'h1);
    lit("exe_haz_stall1", 32'(stall1), 32'h0);
    cyc();
    lit("exe_haz_bubble0", 32'(if0.valid_out), 32'h0);
    lit("exe_haz_issue1", 32'(if1.valid_out), 32'h1);
    exe_mem_read = 1'b1; #1;
    lit("load_use_stall1", 32'(stall1), 32'h1);
    cyc();
    lit("load_use_bubble1", 32'(if1.valid_out), 32'h0);
    exe_wb_en = 1'b0; exe_mem_read = 1'b0; cyc();
    lit("haz_clear_issue0", 32'(if0.valid_out), 32'h1);
    mem_wb_en = 1'b1; mem_dest = 4'd3; cyc();
    lit("mem_haz_bubble0", 32'(if0.valid_out), 32'h0);
    mem_wb_en = 1'b0;

    // Same-cycle write-back bypass
    issue(I_MOV, 32'h104); wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h0000DEAD; cyc();
    lit("bypass_rm", if0.rm_val, 32'h0000DEAD);
    lit("bypass_cmd", 32'(if0.exec_cmd), 32'h1);
    wb_en = 1'b0; cyc();
    lit("rf_written_rm", if0.rm_val, 32'h0000DEAD);

    // Condition codes
    status_reg = 4'b0000; issue(I_ADDEQ, 32'h108); cyc();
    lit("eq_false_valid", 32'(if0.valid_out), 32'h0);
    lit("eq_false_ctrl", 32'({if0.exec_cmd, if0.wb_en_out}), 32'h0);
    status_reg = 4'b0100; cyc();
    lit("eq_true_valid", 32'(if0.valid_out), 32'h1);
    issue(I_ADDNV, 32'h10C); cyc();
    lit("nv_valid", 32'(if0.valid_out), 32'h0);
    for (int st = 0; st < 16; st += 5) begin
      status_reg = 4'(st);
      for (int c = 0; c < 16; c++) begin
        issue({4'(c), I_ADD[27:0]}, 32'(32'h200 + c * 4));
        cyc();
      end
    end
    status_reg = 4'b0000;

    // Decode sweep through the model
    for (int i = 0; i < 10; i++) begin
      issue(sweep[i], 32'(32'h300 + i * 4));
      cyc();
    end
    instr_valid = 1'b0; cyc();

    // Hold for three cycles, then flush
    issue(I_ADD, 32'h400); cyc();
    ex_ready = 1'b0; issue(I_CMP, 32'h404);
    for (int i = 0; i < 3; i++) begin
      cyc();
      lit("hold_pc", if0.pc_out, 32'h400);
      lit("hold_stall", 32'(stall0), 32'h1);
    end
    flush = 1'b1; cyc();
    lit("flush_valid", 32'(if0.valid_out), 32'h0);
    flush = 1'b0; ex_ready = 1'b1;

    // Flush together with a hazard
    issue(I_ADD, 32'h500); exe_wb_en = 1'b1; exe_dest = 4'd3; flush = 1'b1; #1;
    lit("flush_haz_stall", 32'(stall0), 32'h1);
    cyc();
    lit("flush_haz_valid", 32'(if0.valid_out), 32'h0);
    flush = 1'b0; exe_wb_en = 1'b0; cyc();

    // Reset in the middle of a hold
    issue(I_ADD, 32'h600); cyc();
    ex_ready = 1'b0; cyc();
    lit("pre_rst_stall", 32'(stall0), 32'h1);
    rst = 1'b1; instr_valid = 1'b0; cyc();
    lit("rst_valid", 32'(if0.valid_out), 32'h0);
    lit("rst_pc", if0.pc_out, 32'h0);
    lit("rst_stall", 32'(stall0), 32'h0);
    rst = 1'b0; ex_ready = 1'b1;
    issue(I_ADD, 32'h700); cyc();
    lit("post_rst_rn", if0.rn_val, 32'h0);
    lit("post_rst_rm", if1.rm_val, 32'h0);
    instr_valid = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
